// File: rtl/cntr.sv
// Frame bit counter for the USRT transmitter.
// Walks start, data, optional parity and stop bit positions, one per en_usrt rising edge while RTS allows.
module cntr #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       START,
    input  logic       par_en,
    input  logic       en_usrt,
    input  logic       RTS,
    output logic       max,
    output logic [5:0] cout
);
    typedef enum logic {IDLE, RUN} StateT;

    localparam logic [5:0] LastBase = 6'(DATA_BITS + 1);

    StateT      r_state;
    StateT      w_stateNext;
    logic       r_enQ;
    logic       r_parQ;
    logic [5:0] r_cout;
    logic [5:0] w_coutNext;
    logic [5:0] w_last;
    logic       w_tick;
    logic       w_atLast;

    // One tick per en_usrt rising edge, however long the high phase lasts.
    assign w_tick   = en_usrt & ~r_enQ;
    assign w_last   = LastBase + {5'd0, r_parQ};
    assign w_atLast = (r_cout == w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cout  <= '0;
            r_enQ   <= 1'b0;
            r_parQ  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cout  <= w_coutNext;
            r_enQ   <= en_usrt;
            if (r_state == IDLE && START) begin
                r_parQ <= par_en;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_coutNext  = r_cout;
        case (r_state)
            IDLE: begin
                w_coutNext = '0;
                if (START) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_tick && RTS) begin
                    if (w_atLast) begin
                        w_coutNext  = '0;
                        w_stateNext = IDLE;
                    end else begin
                        w_coutNext = r_cout + 6'd1;
                    end
                end
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    always_comb begin
        max  = (r_state == RUN) && w_atLast;
        cout = r_cout;
    end
endmodule

// File: tb/tb_cntr.sv
// Self-checking bench for cntr: directed frames with literal expectations, then
// randomized traffic compared every cycle against a frame-level reference model.
module tb_cntr;
    localparam int DataBits = 8;

    logic       clk;
    logic       rst;
    logic       START;
    logic       par_en;
    logic       en_usrt;
    logic       RTS;
    logic       max;
    logic [5:0] cout;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 0;

    // Reference model: frame in progress, number of bits already sent, frame length.
    bit mBusy;
    int mSent;
    int mLen;
    bit mPrevEn;
    bit mTick;

    cntr #(.DATA_BITS(DataBits)) dut (
        .clk     (clk),
        .rst     (rst),
        .START   (START),
        .par_en  (par_en),
        .en_usrt (en_usrt),
        .RTS     (RTS),
        .max     (max),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A frame is start + data + optional parity + stop; it ends once all its bits are sent.
    always @(posedge clk) begin
        if (rst) begin
            mBusy   = 1'b0;
            mSent   = 0;
            mLen    = 0;
            mPrevEn = 1'b0;
        end else begin
            mTick   = en_usrt && !mPrevEn;
            mPrevEn = en_usrt;
            if (!mBusy) begin
                if (START) begin
                    mBusy = 1'b1;
                    mSent = 0;
                    mLen  = DataBits + 2 + (par_en ? 1 : 0);
                end
            end else if (mTick && RTS) begin
                mSent = mSent + 1;
                if (mSent == mLen) begin
                    mBusy = 1'b0;
                    mSent = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            logic       expMax;
            logic [5:0] expCout;
            expCout = 6'(mSent);
            expMax  = mBusy && (mSent == mLen - 1);
            nChecks++;
            if (cout !== expCout || max !== expMax) begin
                nFails++;
                $display("[TB] FAIL model t=%0t cout=%0d max=%b expected cout=%0d max=%b",
                         $time, cout, max, expCout, expMax);
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic p, input logic e, input logic r);
        START   = s;
        par_en  = p;
        en_usrt = e;
        RTS     = r;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            en_usrt = 1'b1;
            step(1);
            en_usrt = 1'b0;
            step(1);
        end
    endtask

    task automatic checkOutput(input string name, input int expCout, input logic expMax);
        nChecks++;
        if (cout !== 6'(expCout) || max !== expMax) begin
            nFails++;
            $display("[TB] FAIL %s cout=%0d max=%b expected cout=%0d max=%b",
                     name, cout, max, expCout, expMax);
        end
    endtask

    initial begin
        applyStimulus(0, 0, 0, 1);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        checkEn = 1;
        checkOutput("reset", 0, 0);

        tick(5);
        checkOutput("idleHold", 0, 0);

        // Basic frame, START held for two cycles.
        applyStimulus(1, 0, 0, 1);
        step(2);
        START = 1'b0;
        checkOutput("startRun", 0, 0);
        tick(1);
        checkOutput("firstBit", 1, 0);
        tick(8);
        checkOutput("lastBit", 9, 1);
        en_usrt = 1'b1;
        step(1);
        checkOutput("frameEnd", 0, 0);
        en_usrt = 1'b0;
        step(1);

        // Parity frame; par_en dropped mid-frame must not shorten it.
        applyStimulus(1, 1, 0, 1);
        step(1);
        applyStimulus(0, 0, 0, 1);
        tick(9);
        checkOutput("parBit9", 9, 0);
        tick(1);
        checkOutput("parLast", 10, 1);
        tick(1);
        checkOutput("parEnd", 0, 0);

        // Flow control.
        applyStimulus(1, 0, 0, 1);
        step(1);
        START = 1'b0;
        tick(4);
        checkOutput("rtsBefore", 4, 0);
        RTS = 1'b0;
        tick(6);
        checkOutput("rtsHeld", 4, 0);
        RTS = 1'b1;
        tick(1);
        checkOutput("rtsResume", 5, 0);
        tick(5);
        checkOutput("rtsEnd", 0, 0);

        // Reset mid-frame.
        applyStimulus(1, 0, 0, 1);
        step(1);
        START = 1'b0;
        tick(6);
        checkOutput("preReset", 6, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("midReset", 0, 0);
        tick(3);
        checkOutput("noRestart", 0, 0);

        // Long high phase, then START held across frame end.
        applyStimulus(1, 0, 0, 1);
        step(1);
        en_usrt = 1'b1;
        step(5);
        checkOutput("longHigh", 1, 0);
        en_usrt = 1'b0;
        step(1);
        checkOutput("longLow", 1, 0);
        tick(8);
        checkOutput("b2bLast", 9, 1);
        en_usrt = 1'b1;
        step(1);
        checkOutput("b2bIdle", 0, 0);
        en_usrt = 1'b0;
        step(1);
        tick(1);
        checkOutput("b2bRestart", 1, 0);
        START = 1'b0;
        tick(9);
        checkOutput("b2bEnd", 0, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            START = ($urandom_range(0, 7) == 0);
            par_en = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) en_usrt = ~en_usrt;
            RTS = ($urandom_range(0, 99) < 85);
            step(1);
        end
        rst = 1'b0;
        step(2);
        checkEn = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/cntr.md
# cntr

Frame bit counter for the synchronous serial (USRT) transmitter. On START it sequences one frame: start bit, DATA_BITS data bits, an optional parity bit and a stop bit. It advances one bit position per rising edge of the bit-rate enable `en_usrt`, and only while `RTS` permits. It drives the current bit index to the transmit shift/mux logic and flags the last bit of the frame.

## Interface
- DATA_BITS, default 8: number of data bits per frame. Legal range 1..60, so the last index fits in 6 bits.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- START  input  1  frame request, level-sampled; honoured only in IDLE.
- par_en  input  1  parity bit included in the frame; latched when the frame starts.
- en_usrt  input  1  bit-rate enable level; each 0→1 transition is one bit tick.
- RTS  input  1  transmit permission; ticks are ignored while low.
- max  output  1  high while the counter sits on the last bit of the frame.
- cout  output  6  current bit index within the frame; 0 is the start bit.

## Operation
- Tick detect: register en_q <= en_usrt every cycle, in every state. tick = en_usrt & ~en_q, so exactly one tick per rising edge regardless of high-phase length.
- LAST = DATA_BITS + 1 + par_q, where par_q is the latched par_en. Default: 9 without parity (10-bit frame), 10 with parity (11-bit frame).
- States: IDLE, RUN.
- IDLE:
  - cout = 0, max = 0.
  - If START = 1: latch par_q <= par_en, go to RUN with cout = 0.
  - A tick in the same cycle is not counted.
- RUN, on a cycle with tick & RTS:
  - If cout < LAST: cout <= cout + 1.
  - If cout == LAST: cout <= 0 and go to IDLE.
- RUN, otherwise: cout holds.
- RUN ignores START; par_en changes mid-frame have no effect.
- max = (state == RUN) && (cout == LAST). It is a registered-state decode with no combinational path from inputs.
- RTS low in RUN freezes cout and max. When RTS returns high, counting resumes on the next tick. en_q keeps tracking, so a rising edge that occurred while RTS was low is not replayed.
- Back-to-back frames: if START is still high when the FSM re-enters IDLE, a new frame starts on the following cycle.
- cout never exceeds LAST and never wraps past it.

## Timing
- Reset values: state IDLE, cout 0, max 0, en_q 0, par_q 0. rst has priority over every other input.
- Reset mid-frame returns the block to IDLE on that clock edge; the partial frame is dropped.
- START to RUN: 1 clock. cout updates on the clock edge where en_usrt is first sampled high after being sampled low.
- A frame occupies LAST+1 accepted ticks. max is high from the edge of tick LAST until the edge of tick LAST+1.
- With en_usrt toggling every clock (rising edge every 2 clocks), each bit lasts 2 clocks.

## Test plan
- Reset: after rst, drive START=0 and toggle en_usrt → cout stays 0 and max stays 0 in IDLE indefinitely.
- Basic frame, par_en=0, RTS=1, START pulsed 2 cycles, en_usrt toggling each clock:
  - cout steps 0,1,…,9, one step per en_usrt rising edge.
  - max is high only while cout=9.
  - After the 10th tick, cout=0, state is IDLE, max=0.
- Parity frame, par_en=1 at START: cout reaches 10 with max high, then returns to 0. Changing par_en to 0 mid-frame does not shorten the frame.
- Flow control: deassert RTS at cout=4 for 6 ticks → cout holds 4 and max stays 0. After RTS rises, the next tick gives cout=5.
- Reset mid-frame: assert rst at cout=6 → next cycle cout=0, max=0, IDLE. START is then required to begin a new frame.
- Long en_usrt high phase (held high 5 clocks) counts as one tick. START held high across frame end starts a new frame 1 cycle after IDLE.
